key_input_conditioner: RTL and testbench

//  Board-input front end that produces the strobes and operands the control core consumes.
//  - Synchronises and debounces the active-low KEY pushbuttons.
//  - Synchronises the SW slide switches.
//  - Emits one-cycle press/release pulses per key.
//  - Snapshots the switch word on every accepted press, so core save/submit operands are stable.
//  - Sits between the board pins and the core, inside the top-level wrapper.

---
 rtl/key_input_pkg.sv | 11 +
 rtl/key_debounce_fsm.sv | 81 ++++++++
 rtl/key_input_conditioner.sv | 71 +++++++
 tb/tb_key_input_conditioner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/key_input_pkg.sv
// Shared types and default sizing for the board key/switch input front end.
package key_input_pkg;

  typedef enum logic [1:0] {KS_UP, KS_ARM_DN, KS_DOWN, KS_ARM_UP} key_state_t;

  localparam int N_KEYS_DEF          = 4;
  localparam int SW_W_DEF            = 10;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/key_debounce_fsm.sv
// One pushbuttons worth of conditioning: synchroniser, debounce FSM and hold counter.
//
// state     | meaning
// KS_UP     | key released and stable
// KS_ARM_DN | press seen, waiting for it to hold
// KS_DOWN   | key held and stable
// KS_ARM_UP | release seen, waiting for it to hold (level still 1)
module key_debounce_fsm
  import key_input_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The UP/DOWN cycle that spots the change counts as the first held cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync;
  logic                   p;
  key_state_t             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   press_nxt, release_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], key_n};
  end

  assign p = ~sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      KS_UP:     if (p) state_nxt = KS_ARM_DN;
      KS_ARM_DN: begin
        if (!p) state_nxt = KS_UP;
        else if (cnt == CNT_LAST) begin
          state_nxt = KS_DOWN;
          press_nxt = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      KS_DOWN:   if (!p) state_nxt = KS_ARM_UP;
      KS_ARM_UP: begin
        if (p) state_nxt = KS_DOWN;
        else if (cnt == CNT_LAST) begin
          state_nxt   = KS_UP;
          release_nxt = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      default:   state_nxt = KS_UP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= KS_UP;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  assign level = (state == KS_DOWN) || (state == KS_ARM_UP);

endmodule

// File: rtl/key_input_conditioner.sv
// Board input front end: debounced key strobes, synchronised switches and a
// switch snapshot taken on every accepted key press.
module key_input_conditioner
  import key_input_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int SW_W            = SW_W_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  localparam int KW             = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [SW_W-1:0]   sw_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [SW_W-1:0]   sw_sync,
  output logic [SW_W-1:0]   sw_snapshot,
  output logic              snap_valid,
  output logic [KW-1:0]     snap_key
);

  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_pipe;
  logic [KW-1:0]                    press_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_pipe <= '0;
    else        sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], sw_raw};
  end

  assign sw_sync = sw_pipe[SYNC_STAGES-1];

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    key_debounce_fsm #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_n         (key_n[gi]),
      .level         (key_level[gi]),
      .press_pulse   (key_press[gi]),
      .release_pulse (key_release[gi])
    );
  end

  // Lowest-index pressing key wins when several are accepted together.
  always_comb begin
    press_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key_press[i]) press_idx = KW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_snapshot <= '0;
      snap_valid  <= 1'b0;
      snap_key    <= '0;
    end else begin
      snap_valid <= |key_press;
      if (|key_press) begin
        sw_snapshot <= sw_sync;
        snap_key    <= press_idx;
      end
    end
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with a short debounce window.
module tb_key_input_conditioner;

  localparam int NK  = 4;
  localparam int SWW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NK-1:0]   key_n;
  logic [SWW-1:0]  sw_raw;
  logic [NK-1:0]   key_level, key_press, key_release;
  logic [SWW-1:0]  sw_sync, sw_snapshot;
  logic            snap_valid;
  logic [1:0]      snap_key;

  int checks   = 0;
  int failures = 0;
  int n_press[NK];
  int n_rel[NK];
  int n_snap;

  key_input_conditioner #(
    .N_KEYS          (NK),
    .SW_W            (SWW),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .sw_raw      (sw_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .sw_sync     (sw_sync),
    .sw_snapshot (sw_snapshot),
    .snap_valid  (snap_valid),
    .snap_key    (snap_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and tallying pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if (key_press[k])   n_press[k]++;
        if (key_release[k]) n_rel[k]++;
      end
      if (snap_valid) n_snap++;
    end
  endtask

  task automatic clr();
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0;
      n_rel[k]   = 0;
    end
    n_snap = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   32'(key_level),   0);
    chk({tag, "_press"},   32'(key_press),   0);
    chk({tag, "_release"}, 32'(key_release), 0);
    chk({tag, "_sw_sync"}, 32'(sw_sync),     0);
    chk({tag, "_snap"},    32'(sw_snapshot), 0);
    chk({tag, "_svalid"},  32'(snap_valid),  0);
    chk({tag, "_skey"},    32'(snap_key),    0);
  endtask

  initial begin
    rst_n  = 1'b0;
    key_n  = '1;
    sw_raw = 10'h3FF;
    clr();
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(3);

    // Clean press of key 2; switches read 3FF by now.
    clr();
    key_n[2] = 1'b0;
    step(9);
    chk("t1_press_c9", 32'(key_press), 0);
    step(1);
    chk("t1_press_c10", 32'(key_press), 4'b0100);
    chk("t1_level_c10", 32'(key_level), 4'b0100);
    step(1);
    chk("t1_press_c11", 32'(key_press), 0);
    chk("t1_svalid_c11", 32'(snap_valid), 1);
    chk("t1_skey", 32'(snap_key), 2);
    chk("t1_snapshot", 32'(sw_snapshot), 10'h3FF);
    step(9);
    chk("t1_level_hold", 32'(key_level), 4'b0100);
    chk("t1_npress", 32'(n_press[2]), 1);

    // Release of key 2.
    clr();
    key_n[2] = 1'b1;
    step(9);
    chk("t5_rel_c9", 32'(key_release), 0);
    chk("t5_level_c9", 32'(key_level), 4'b0100);
    step(1);
    chk("t5_rel_c10", 32'(key_release), 4'b0100);
    chk("t5_level_c10", 32'(key_level), 0);
    step(2);
    chk("t5_nrel", 32'(n_rel[2]), 1);
    chk("t5_nsnap", 32'(n_snap), 0);

    // Bounce on key 0: only the final fall is accepted.
    clr();
    key_n[0] = 1'b0;
    step(5);
    key_n[0] = 1'b1;
    step(1);
    key_n[0] = 1'b0;
    step(9);
    chk("t2_npress_early", 32'(n_press[0]), 0);
    step(1);
    chk("t2_press_c10", 32'(key_press), 4'b0001);
    step(10);
    chk("t2_npress", 32'(n_press[0]), 1);
    key_n = '1;
    step(14);

    // Switch sync latency and snapshot from key 3.
    sw_raw = 10'h2A5;
    step(1);
    chk("t3_sync_c1", 32'(sw_sync), 10'h3FF);
    step(1);
    chk("t3_sync_c2", 32'(sw_sync), 10'h2A5);
    clr();
    key_n[3] = 1'b0;
    step(10);
    chk("t3_press", 32'(key_press), 4'b1000);
    chk("t3_svalid_c10", 32'(snap_valid), 0);
    step(1);
    chk("t3_svalid_c11", 32'(snap_valid), 1);
    chk("t3_snapshot", 32'(sw_snapshot), 10'h2A5);
    chk("t3_skey", 32'(snap_key), 3);
    step(1);
    chk("t3_svalid_c12", 32'(snap_valid), 0);
    sw_raw = 10'h155;
    clr();
    key_n = '1;
    step(14);
    chk("t3_rel_nsnap", 32'(n_snap), 0);
    chk("t3_snap_keep", 32'(sw_snapshot), 10'h2A5);
    chk("t3_nrel", 32'(n_rel[3]), 1);

    // Simultaneous presses of keys 1 and 3.
    clr();
    key_n = 4'b0101;
    step(10);
    chk("t4_press", 32'(key_press), 4'b1010);
    step(1);
    chk("t4_svalid", 32'(snap_valid), 1);
    chk("t4_skey", 32'(snap_key), 1);
    chk("t4_snapshot", 32'(sw_snapshot), 10'h155);
    step(5);
    chk("t4_nsnap", 32'(n_snap), 1);

    // Key 3 releases while key 0 presses; key 1 stays held.
    key_n = 4'b1100;
    step(10);
    chk("mix_press", 32'(key_press), 4'b0001);
    chk("mix_release", 32'(key_release), 4'b1000);
    chk("mix_level", 32'(key_level), 4'b0011);
    step(1);
    chk("mix_skey", 32'(snap_key), 0);
    key_n = '1;
    step(14);
    chk("mix_level_end", 32'(key_level), 0);

    // Reset in the middle of a press debounce of key 2.
    clr();
    key_n[2] = 1'b0;
    step(5);
    rst_n = 1'b0;
    step(1);
    chk_all_zero("t6_rst");
    step(2);
    rst_n = 1'b1;
    step(9);
    chk("t6_npress_early", 32'(n_press[2]), 0);
    step(1);
    chk("t6_press_c10", 32'(key_press), 4'b0100);
    chk("t6_level", 32'(key_level), 4'b0100);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
